// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data memory arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_MAX = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Rotating-priority picker: the requester at ptr_i has top priority, then ptr_i+1, ... wrapping.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; a requester that is not picked simply keeps its request up.
//
// Ports: req_i   per-requester request
//        ptr_i   index of the highest-priority requester
//        gnt_o   one-hot grant (all zero when nothing is requested)
//        idx_o   winner index (0 when nothing is requested)
//        vld_o   a winner exists
module dmem_arb_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    int rank;
    int best_rank;

    // Each requester's rank is its distance from ptr_i going upward with wrap;
    // the lowest-ranked active requester wins.
    always_comb begin
        rank      = 0;
        best_rank = NUM_REQ;
        idx_o     = '0;
        gnt_o     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rank = (i >= int'(ptr_i)) ? (i - int'(ptr_i)) : (i + NUM_REQ - int'(ptr_i));
            if (req_i[i] && (rank < best_rank)) begin
                best_rank = rank;
                idx_o     = IDX_W'(i);
            end
        end
        vld_o = (best_rank < NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i] = vld_o && (idx_o == IDX_W'(i));
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates single-cycle load/store access to the shared data memory, with optional burst lock.
// Latency: grant 0 cycles (combinational), read data 1 cycle; one transaction per cycle.
// Backpressure: a losing requester holds req/we/addr/wdata until it sees gnt; it may withdraw.
//
// Build option: DMEM_ARB_RR_EN defined -> round-robin pointer; undefined -> fixed priority
// (lowest index wins).
//
// Ports: clk, rst_n                 clock, async active-low reset
//        req/we/lock/addr/wdata     per-requester request, write flag, lock, address, write data
//        gnt                        one-hot grant, same cycle as request
//        rvalid, rdata              one-hot read valid and shared registered read data, next cycle
//        mem_wen, mem_read_addr,
//        mem_write_addr, mem_wdata  memory command, driven from the winner (0 when idle)
//        mem_rdata                  memory asynchronous read data
module data_mem_arbiter #(
    parameter int DATA_PATH_WIDTH = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int NUM_REQ         = 2,
    parameter int LOCK_MAX        = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req,
    input  logic [NUM_REQ-1:0]                       we,
    input  logic [NUM_REQ-1:0]                       lock,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]       addr,
    input  logic [NUM_REQ-1:0][DATA_PATH_WIDTH-1:0]  wdata,
    output logic [NUM_REQ-1:0]                       gnt,
    output logic [NUM_REQ-1:0]                       rvalid,
    output logic [DATA_PATH_WIDTH-1:0]               rdata,
    output logic                                     mem_wen,
    output logic [ADDR_WIDTH-1:0]                    mem_read_addr,
    output logic [ADDR_WIDTH-1:0]                    mem_write_addr,
    output logic [DATA_PATH_WIDTH-1:0]               mem_wdata,
    input  logic [DATA_PATH_WIDTH-1:0]               mem_rdata
);
    import dmem_arb_pkg::*;

    localparam int IDX_W = idx_w(NUM_REQ);
    // With LOCK_MAX = 0 the counter is only informational and saturates.
    localparam int CNT_W = (LOCK_MAX == 0) ? 8 : $clog2(LOCK_MAX + 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0]     rvalid_q;
    logic [DATA_PATH_WIDTH-1:0] rdata_q;

    logic [NUM_REQ-1:0]     owner_oh;
    logic [NUM_REQ-1:0]     req_elig;
    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IDX_W-1:0]       win_idx;
    logic                   pick_vld;
    logic                   win_vld;
    logic [IDX_W-1:0]       ptr;

    // While locked, only the owner is eligible and only while it still asserts lock;
    // a dropped req or lock therefore yields no grant and ends the lock.
    assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign req_elig = (state_q == ARB_LOCKED) ? (req & lock & owner_oh) : req;

    dmem_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (req_elig),
        .ptr_i (ptr),
        .gnt_o (pick_gnt),
        .idx_o (win_idx),
        .vld_o (pick_vld)
    );

    assign gnt     = rst_n ? pick_gnt : '0;
    assign win_vld = rst_n & pick_vld;

    always_comb begin
        mem_wen        = 1'b0;
        mem_read_addr  = '0;
        mem_write_addr = '0;
        mem_wdata      = '0;
        if (win_vld) begin
            mem_wen        = we[win_idx];
            mem_read_addr  = addr[win_idx];
            mem_write_addr = addr[win_idx];
            mem_wdata      = wdata[win_idx];
        end
    end

`ifdef DMEM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        ptr_d = ptr_q;
        if (win_vld) begin
            ptr_d = next_idx(win_idx);
        end else if (rst_n && (state_q == ARB_LOCKED)) begin
            ptr_d = next_idx(owner_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // Lock FSM. The grant that brings lock_cnt to LOCK_MAX still executes and releases the lock.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_vld && lock[win_idx] && (LOCK_MAX != 1)) begin
                    state_d    = ARB_LOCKED;
                    owner_d    = win_idx;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            ARB_LOCKED: begin
                if (win_vld) begin
                    if ((LOCK_MAX != 0) && (int'(lock_cnt_q) + 1 >= LOCK_MAX)) begin
                        state_d    = ARB_IDLE;
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q != {CNT_W{1'b1}}) begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = ARB_IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= gnt & ~we;
            if (|(gnt & ~we)) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural reference model and a bench-side memory.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_data_mem_arbiter;

    localparam int NR = 2;
    localparam int LM = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NR-1:0]        req = '0;
    logic [NR-1:0]        we = '0;
    logic [NR-1:0]        lock = '0;
    logic [NR-1:0][7:0]   addr = '0;
    logic [NR-1:0][7:0]   wdata = '0;
    logic [NR-1:0]        gnt;
    logic [NR-1:0]        rvalid;
    logic [7:0]           rdata;
    logic                 mem_wen;
    logic [7:0]           mem_read_addr;
    logic [7:0]           mem_write_addr;
    logic [7:0]           mem_wdata;
    logic [7:0]           mem_rdata;

    logic [7:0] mem  [256];
    logic [7:0] mmem [256];

    int n_vec = 0;
    int n_err = 0;

    data_mem_arbiter #(
        .DATA_PATH_WIDTH (8),
        .ADDR_WIDTH      (8),
        .NUM_REQ         (NR),
        .LOCK_MAX        (LM)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .we             (we),
        .lock           (lock),
        .addr           (addr),
        .wdata          (wdata),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .mem_wen        (mem_wen),
        .mem_read_addr  (mem_read_addr),
        .mem_write_addr (mem_write_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // Bench-side data memory: asynchronous read, write at the clock edge.
    assign mem_rdata = mem[mem_read_addr];
    always @(posedge clk) begin
        if (rst_n && mem_wen) mem[mem_write_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_locked;
    int         m_owner;
    int         m_cnt;
    int         m_ptr;
    logic [NR-1:0] m_rvalid;
    logic [7:0] m_rdata;

    always @(negedge clk) begin
        int w;
        logic [NR-1:0] e_gnt;
        if (!rst_n) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_wen", 32'(mem_wen), 0);
            chk("rst_rvalid", 32'(rvalid), 0);
            chk("rst_rdata", 32'(rdata), 0);
            chk("rst_raddr", 32'(mem_read_addr), 0);
            m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
            m_rvalid = '0; m_rdata = '0;
        end else begin
            w = -1;
            if (m_locked) begin
                if (req[m_owner] && lock[m_owner]) w = m_owner;
            end else begin
                for (int k = NR - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
                end
            end
            e_gnt = (w >= 0) ? NR'(1 << w) : '0;
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("mem_wen", 32'(mem_wen), (w >= 0) ? 32'(we[w]) : 0);
            chk("raddr", 32'(mem_read_addr), (w >= 0) ? 32'(addr[w]) : 0);
            chk("waddr", 32'(mem_write_addr), (w >= 0) ? 32'(addr[w]) : 0);
            chk("wdata", 32'(mem_wdata), (w >= 0) ? 32'(wdata[w]) : 0);
            chk("rvalid", 32'(rvalid), 32'(m_rvalid));
            chk("rdata", 32'(rdata), 32'(m_rdata));
            // advance model to the next cycle
            m_rvalid = '0;
            if (w >= 0) begin
                if (we[w]) begin
                    mmem[addr[w]] = wdata[w];
                end else begin
                    m_rvalid = e_gnt;
                    m_rdata  = mmem[addr[w]];
                end
`ifdef DMEM_ARB_RR_EN
                m_ptr = (w + 1) % NR;
`endif
                if (!m_locked) begin
                    if (lock[w] && LM != 1) begin
                        m_locked = 1; m_owner = w; m_cnt = 1;
                    end
                end else begin
                    m_cnt++;
                    if (LM != 0 && m_cnt >= LM) begin
                        m_locked = 0; m_cnt = 0;
                    end
                end
            end else if (m_locked) begin
                m_locked = 0; m_cnt = 0;
`ifdef DMEM_ARB_RR_EN
                m_ptr = (m_owner + 1) % NR;
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [NR-1:0] alt_exp [4];
    logic [NR-1:0] g [20];

    initial begin
        int cnt;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'(i * 3 + 1);
            mmem[i] = 8'(i * 3 + 1);
        end
`ifdef DMEM_ARB_RR_EN
        alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        alt_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        #1 rst_n = 1'b0;
        repeat (2) next_cycle();
        chk("reset_gnt_lit", 32'(gnt), 0);
        chk("reset_rdata_lit", 32'(rdata), 0);
        rst_n = 1'b1;

        // both requesters reading
        req = 2'b11; we = 2'b00; addr[0] = 8'h10; addr[1] = 8'h20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_gnt", 32'(gnt), 32'(alt_exp[i]));
            next_cycle();
        end
        req = '0;
        next_cycle();

        // read-after-write through the memory
        req = 2'b01; we = 2'b01; addr[0] = 8'h33; wdata[0] = 8'hA5;
        @(negedge clk);
        chk("raw_wr_gnt", 32'(gnt), 32'h1);
        next_cycle();
        req = 2'b10; we = 2'b00; addr[1] = 8'h33;
        @(negedge clk);
        chk("raw_rd_gnt", 32'(gnt), 32'h2);
        next_cycle();
        req = '0;
        chk("raw_rvalid", 32'(rvalid), 32'h2);
        chk("raw_rdata", 32'(rdata), 32'hA5);
        next_cycle();

        // bounded lock burst by requester 1
        req = 2'b10; lock = 2'b10; addr[1] = 8'h40; addr[0] = 8'h41;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            g[i] = gnt;
            next_cycle();
            req = 2'b11;
        end
        req = '0; lock = '0;
        cnt = 0;
        while (cnt < 20 && g[cnt] == 2'b10) cnt++;
        chk("lock_run_len", 32'(cnt), 16);
        chk("lock_after_gnt", 32'(g[16]), 32'h1);
        next_cycle();

        // owner 0 drops lock after 3 grants
        req = 2'b01; lock = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lock3_gnt", 32'(gnt), 32'h1);
            next_cycle();
            req = 2'b11;
        end
        lock = 2'b00;
        @(negedge clk);
        chk("release_gnt", 32'(gnt), 32'h0);
        next_cycle();
        @(negedge clk);
`ifdef DMEM_ARB_RR_EN
        chk("post_release_gnt", 32'(gnt), 32'h2);
`else
        chk("post_release_gnt", 32'(gnt), 32'h1);
`endif
        next_cycle();
        req = '0;
        next_cycle();

        // reset during a locked read burst
        req = 2'b10; lock = 2'b10; we = 2'b00; addr[1] = 8'h50;
        next_cycle();
        next_cycle();
        chk("pre_rst_rvalid", 32'(rvalid), 32'h2);
        #1 rst_n = 1'b0; req = '0; lock = '0;
        #1;
        chk("async_rst_rvalid", 32'(rvalid), 0);
        chk("async_rst_rdata", 32'(rdata), 0);
        chk("async_rst_gnt", 32'(gnt), 0);
        chk("async_rst_wen", 32'(mem_wen), 0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", 32'(rvalid), 0);
            next_cycle();
        end

        // single requester sweeping the whole address space
        begin
            int gc;
            int rc;
            gc = 0; rc = 0;
            req = 2'b01; we = 2'b00;
            for (int a = 0; a < 256; a++) begin
                addr[0] = 8'(a);
                @(negedge clk);
                if (gnt == 2'b01) gc++;
                if (rvalid == 2'b01) rc++;
                next_cycle();
            end
            req = '0;
            @(negedge clk);
            if (rvalid == 2'b01) rc++;
            chk("sweep_grants", 32'(gc), 256);
            chk("sweep_rvalids", 32'(rc), 256);
            chk("sweep_last_rdata", 32'(rdata), 32'hFE);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
